serial_operand_feeder: RTL

Upstream stage of the bit-serial adder FSM. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. It issues the one-cycle start pulse, then presents the operands LSB-first on A/B, holding each bit for BIT_CYCLES clocks to match the adder's S1→S2→S3 phase rotation. It feeds the adder's carry-out back into CIN for the next bit and reports the final carry.

---
 rtl/serial_operand_feeder_if.sv | 33 +++
 rtl/serial_operand_feeder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/serial_operand_feeder_if.sv
// Handshake and serial-lane bundle between the operand source, the
// serial operand feeder and the bit-serial adder.
interface serial_operand_feeder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             abort;
    logic             cout_fb;
    logic             start;
    logic             seq_rst;
    logic             A;
    logic             B;
    logic             CIN;
    logic             busy;
    logic             done;
    logic             carry_out;

    // Operand source side: supplies operands, abort and the adder carry.
    modport master (
        output in_valid, in_a, in_b, in_cin, abort, cout_fb,
        input  in_ready, start, seq_rst, A, B, CIN, busy, done, carry_out
    );

    // Feeder side.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, abort, cout_fb,
        output in_ready, start, seq_rst, A, B, CIN, busy, done, carry_out
    );
endinterface

// File: rtl/serial_operand_feeder.sv
// Serial operand feeder: accepts a WIDTH-bit operand pair plus carry-in,
// pulses start to the bit-serial adder, then streams the operands LSB-first,
// holding each bit for BIT_CYCLES clocks and looping the adder carry back.
module serial_operand_feeder #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    serial_operand_feeder_if.slave bus
);
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PH_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WIDTH - 1);
    localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    // Operand bits not yet presented; bit 0 is the next one to go out.
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic [BIT_W-1:0]  bit_idx;
    logic [PH_W-1:0]   phase;
    // The carry register doubles as the CIN lane driven to the adder.
    logic              carry_reg;
    logic              start_r;
    logic              seq_rst_r;
    logic              a_r;
    logic              b_r;
    logic              busy_r;
    logic              done_r;
    logic              carry_out_r;

    // NOTE: in_ready is decoded straight from the state so an accept can
    // happen in the very first IDLE cycle; every other output is a flop.
    assign bus.in_ready  = (state == IDLE);
    assign bus.start     = start_r;
    assign bus.seq_rst   = seq_rst_r;
    assign bus.A         = a_r;
    assign bus.B         = b_r;
    assign bus.CIN       = carry_reg;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.carry_out = carry_out_r;

    // Control FSM with registered outputs; abort wins over bit sequencing.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            bit_idx     <= '0;
            phase       <= '0;
            carry_reg   <= 1'b0;
            start_r     <= 1'b0;
            seq_rst_r   <= 1'b0;
            a_r         <= 1'b0;
            b_r         <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            carry_out_r <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge values and the pulse defaults below are safely
            // overridden by later assignments in the same block.
            start_r   <= 1'b0;
            seq_rst_r <= 1'b0;
            done_r    <= 1'b0;

            if ((state == START || state == SHIFT) && bus.abort) begin
                state     <= IDLE;
                seq_rst_r <= 1'b1;
                busy_r    <= 1'b0;
                a_r       <= 1'b0;
                b_r       <= 1'b0;
                carry_reg <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.in_valid) begin
                            state     <= START;
                            start_r   <= 1'b1;
                            busy_r    <= 1'b1;
                            a_sr      <= bus.in_a >> 1;
                            b_sr      <= bus.in_b >> 1;
                            a_r       <= bus.in_a[0];
                            b_r       <= bus.in_b[0];
                            carry_reg <= bus.in_cin;
                            bit_idx   <= '0;
                            phase     <= '0;
                        end
                    end

                    START: begin
                        state   <= SHIFT;
                        bit_idx <= '0;
                        phase   <= '0;
                    end

                    SHIFT: begin
                        if (phase == LAST_PHASE) begin
                            carry_reg <= bus.cout_fb;
                            phase     <= '0;
                            if (bit_idx == LAST_BIT) begin
                                state       <= DONE;
                                done_r      <= 1'b1;
                                busy_r      <= 1'b0;
                                carry_out_r <= bus.cout_fb;
                            end else begin
                                bit_idx <= bit_idx + BIT_W'(1);
                                a_r     <= a_sr[0];
                                b_r     <= b_sr[0];
                                a_sr    <= a_sr >> 1;
                                b_sr    <= b_sr >> 1;
                            end
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end

                    DONE: begin
                        state <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
